// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// wait-state limit used by the APB completer and its register file.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 8;
  localparam int APB_WAIT_MAX   = 15;
  localparam int APB_WAIT_W     = 4;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACCESS = 1'b1;

endpackage

// File: rtl/apb_regfile.sv
// NUM_REGS x DATA_WIDTH register array with one write port and one
// combinational read port; out-of-range reads return 0 and writes are dropped.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  waddr_ok;
  logic                  raddr_ok;

  assign waddr_ok = {1'b0, waddr} < NUM_REGS_W;
  assign raddr_ok = {1'b0, raddr} < NUM_REGS_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && waddr_ok) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign rdata = raddr_ok ? mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer fronting a register bank, with a fixed number of wait states
// per access and pslverr on addresses beyond the bank.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  fsm_state
);

  localparam logic [ADDR_WIDTH:0]   NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];
  localparam logic [APB_WAIT_W-1:0] WAIT_INIT  = APB_WAIT_W'(WAIT_CYCLES);
  localparam logic [APB_WAIT_W-1:0] WAIT_LAST  = APB_WAIT_W'(1);
  localparam bit                    LOAD_AT_SETUP = (WAIT_CYCLES == 0);

  logic                  state;
  logic [APB_WAIT_W-1:0] wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  addr_ok_q;
  logic                  we;

  // Handshake: a transfer completes on the rising edge where psel, penable and
  // pready are all high; pready is only raised in ACCESS once the wait count is
  // exhausted, and pslverr/prdata are meaningful only in that completing cycle.
  assign addr_ok_q = {1'b0, addr_q} < NUM_REGS_W;
  assign pready    = (state == ST_ACCESS) && (wait_cnt == '0) && psel && penable;
  assign pslverr   = pready && !addr_ok_q;
  assign we        = pready && wr_q && addr_ok_q;
  assign prdata    = prdata_q;
  assign fsm_state = state;

  // In IDLE the read port looks at the live setup address so a zero-wait read
  // can load prdata on the same edge that latches addr_q.
  assign raddr = (state == ST_IDLE) ? paddr : addr_q;

  apb_regfile #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clk  (pclk),
    .rst_n(presetn),
    .we   (we),
    .waddr(addr_q),
    .wdata(pwdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      prdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (psel && !penable) begin
            state    <= ST_ACCESS;
            wait_cnt <= WAIT_INIT;
            addr_q   <= paddr;
            wr_q     <= pwrite;
            if (LOAD_AT_SETUP && !pwrite) prdata_q <= rdata;
          end
        end
        ST_ACCESS: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else if (penable) begin
            if (wait_cnt != '0) begin
              wait_cnt <= wait_cnt - 1'b1;
              if (wait_cnt == WAIT_LAST && !wr_q) prdata_q <= rdata;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: three instances with 0, 2 and 3 wait states,
// directed scenarios plus random traffic against an array-based bank model.
module tb_apb_slave_regbank;

  localparam int NDUT = 3;
  localparam int NREG = 16;
  localparam int WAITS [NDUT] = '{0, 2, 3};

  logic       pclk = 1'b0;
  logic       presetn [NDUT];
  logic       psel    [NDUT];
  logic       penable [NDUT];
  logic       pwrite  [NDUT];
  logic [7:0] paddr   [NDUT];
  logic [7:0] pwdata  [NDUT];
  logic       pready  [NDUT];
  logic [7:0] prdata  [NDUT];
  logic       pslverr [NDUT];
  logic       fsm_state [NDUT];

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_slave_regbank #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .NUM_REGS   (NREG),
      .WAIT_CYCLES(WAITS[g])
    ) u_dut (
      .pclk     (pclk),
      .presetn  (presetn[g]),
      .psel     (psel[g]),
      .penable  (penable[g]),
      .pwrite   (pwrite[g]),
      .paddr    (paddr[g]),
      .pwdata   (pwdata[g]),
      .pready   (pready[g]),
      .prdata   (prdata[g]),
      .pslverr  (pslverr[g]),
      .fsm_state(fsm_state[g])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] model_mem [NDUT][NREG];
  logic [7:0] last_rd [NDUT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear(input int d);
    for (int i = 0; i < NREG; i++) model_mem[d][i] = 8'h00;
    last_rd[d] = 8'h00;
  endtask

  // Entered just after a rising edge; leaves just after the completing edge
  // with psel low, so a following call forms a back-to-back transfer.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    int waits;
    bit done;
    bit in_rng;
    logic [7:0] exp_rd;
    in_rng = (a < NREG);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a;
    pwdata[d] = wr ? wd : 8'($urandom);
    @(negedge pclk);
    check("setup_pready", pready[d], 0);
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    paddr[d] = 8'($urandom);
    pwdata[d] = wd;
    waits = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge pclk);
      if (pready[d]) done = 1'b1;
      else waits++;
    end
    check("completed", done, 1);
    check("wait_states", waits, WAITS[d]);
    check("pslverr", pslverr[d], !in_rng);
    if (!wr) begin
      exp_rd = in_rng ? model_mem[d][a[3:0]] : 8'h00;
      check("prdata", prdata[d], exp_rd);
      last_rd[d] = exp_rd;
    end else begin
      check("prdata_hold", prdata[d], last_rd[d]);
    end
    @(posedge pclk); #1;
    if (wr && in_rng) model_mem[d][a[3:0]] = wd;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  task automatic read_all(input int d);
    for (int i = 0; i < NREG; i++) xfer(d, 1'b0, 8'(i), 8'h00);
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      presetn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0;
      pwrite[d] = 1'b0; paddr[d] = 8'h00; pwdata[d] = 8'h00;
      model_clear(d);
    end
    @(negedge pclk);
    for (int d = 0; d < NDUT; d++) begin
      check("rst_pready", pready[d], 0);
      check("rst_prdata", prdata[d], 0);
      check("rst_pslverr", pslverr[d], 0);
      check("rst_state", fsm_state[d], 0);
    end
    @(posedge pclk); #1;
    for (int d = 0; d < NDUT; d++) presetn[d] = 1'b1;
    idle(1);

    // Zero wait states: write then read, then a back-to-back burst.
    xfer(0, 1'b1, 8'h03, 8'h5A);
    xfer(0, 1'b0, 8'h03, 8'h00);
    xfer(0, 1'b1, 8'h00, 8'h11);
    xfer(0, 1'b1, 8'h0F, 8'h22);
    xfer(0, 1'b0, 8'h00, 8'h00);
    xfer(0, 1'b0, 8'h0F, 8'h00);
    idle(1);
    xfer(0, 1'b1, 8'h20, 8'hFF);
    xfer(0, 1'b0, 8'h20, 8'h00);
    read_all(0);

    // penable without a setup phase must not start a transfer.
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 8'h03;
    @(negedge pclk);
    @(posedge pclk); #1;
    @(negedge pclk);
    check("penable_in_idle_state", fsm_state[0], 0);
    check("penable_in_idle_pready", pready[0], 0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    idle(1);

    // Three wait states: first read after reset.
    xfer(2, 1'b0, 8'h01, 8'h00);

    // Two wait states: abort during the first wait cycle of a write.
    xfer(1, 1'b1, 8'h04, 8'h4C);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h04; pwdata[1] = 8'h77;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(negedge pclk);
    check("abort_wait_pready", pready[1], 0);
    check("abort_wait_state", fsm_state[1], 1);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); #1;
    @(negedge pclk);
    check("abort_idle_state", fsm_state[1], 0);
    @(posedge pclk); #1;
    xfer(1, 1'b0, 8'h04, 8'h00);

    // Reset during the wait state of a write.
    xfer(2, 1'b1, 8'h05, 8'h9C);
    xfer(2, 1'b0, 8'h05, 8'h00);
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h02; pwdata[2] = 8'h33;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    @(negedge pclk); #1;
    presetn[2] = 1'b0;
    #1;
    check("midrst_pready", pready[2], 0);
    check("midrst_prdata", prdata[2], 0);
    check("midrst_pslverr", pslverr[2], 0);
    check("midrst_state", fsm_state[2], 0);
    model_clear(2);
    @(posedge pclk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0; presetn[2] = 1'b1;
    idle(1);
    xfer(2, 1'b0, 8'h02, 8'h00);
    xfer(2, 1'b0, 8'h05, 8'h00);

    // Reset while pready is high drops it without waiting for a clock edge.
    xfer(0, 1'b1, 8'h07, 8'hA5);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h07;
    @(posedge pclk); #1;
    penable[0] = 1'b1;
    @(negedge pclk);
    check("pre_rst_pready", pready[0], 1);
    check("pre_rst_prdata", prdata[0], 8'hA5);
    presetn[0] = 1'b0;
    #1;
    check("async_rst_pready", pready[0], 0);
    check("async_rst_prdata", prdata[0], 0);
    model_clear(0);
    @(posedge pclk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0; presetn[0] = 1'b1;
    idle(1);

    // Random traffic, including out-of-range addresses and back-to-back runs.
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 30; n++) begin
        logic [7:0] a;
        a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 19));
        xfer(d, 1'($urandom_range(0, 1)), a, 8'($urandom));
        if ($urandom_range(0, 1) == 1) idle(1);
      end
      read_all(d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0x0 exp=0x1");
    $fatal(1, "simulation did not finish");
  end

endmodule
